// File: rtl/image_mem_arbiter.sv
// ---------------------------------------------------------------------------
// image_mem_arbiter
//
// Shares the single-port image RAM between the down-sample core (MAR/MDR
// path) and the host loader/dumper. Each request gets one byte-wide access
// through a three-state sequence: IDLE (arbitrate) -> ACCESS (drive the RAM)
// -> ACK (return the completion pulse and read data). When both sides are
// requesting, the side that did not own the last access wins. A steady stream
// from either side therefore cannot lock out the other.
//
// Ports
//   clock, reset                      clock and synchronous active-high reset
//   cpu_req/we/addr/wdata  -> inputs   core request and its fields
//   cpu_ack, cpu_rdata     <- outputs  core completion pulse and read data
//   host_req/we/addr/wdata -> inputs   host request and its fields
//   host_ack, host_rdata   <- outputs  host completion pulse and read data
//   ram_en/we/addr/wdata   <- outputs  RAM control, address and write data
//   ram_rdata              -> input    RAM read data, valid the cycle after ram_en
//   busy                   <- output   high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module image_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;
    typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_owner_q, last_owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                grant_cpu;

    // The core wins when it is alone, or when both ask and the host had the
    // previous access.
    assign grant_cpu = cpu_req && (!host_req || (last_owner_q == OWN_HOST));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_HOST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                // Request fields are captured only here; later changes on the
                // request inputs cannot disturb the access in flight.
                if (cpu_req || host_req) begin
                    state_d = S_ACCESS;
                    if (grant_cpu) begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        owner_d = OWN_HOST;
                        we_d    = host_we;
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                    end
                end
            end
            S_ACCESS: begin
                state_d      = S_ACK;
                last_owner_d = owner_q;
            end
            S_ACK: begin
                state_d = S_IDLE;
                // Keep the read byte so the owner's rdata holds until its next ack.
                if (!we_q) begin
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = ram_rdata;
                    end else begin
                        host_rdata_d = ram_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates the enable directly. A write caught in ACCESS at a reset
    // edge therefore never reaches the array.
    assign ram_en    = (state_q == S_ACCESS) && !reset;
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign cpu_ack   = (state_q == S_ACK) && (owner_q == OWN_CPU);
    assign host_ack  = (state_q == S_ACK) && (owner_q == OWN_HOST);
    assign busy      = (state_q != S_IDLE);

    // During ACK the RAM's registered output is the fresh byte. Afterwards,
    // the captured copy is shown.
    assign cpu_rdata  = (cpu_ack && !we_q)  ? ram_rdata : cpu_rdata_q;
    assign host_rdata = (host_ack && !we_q) ? ram_rdata : host_rdata_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
module tb_image_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clock;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    logic [DW-1:0] mem   [0:65535];
    logic [DW-1:0] model [0:65535];
    logic [DW-1:0] cpu_exp[$];
    logic [DW-1:0] host_exp[$];

    int n_vec = 0;
    int n_err = 0;
    int cpu_ack_cnt = 0;

    image_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM.
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clock) begin
        if (cpu_ack) cpu_ack_cnt <= cpu_ack_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        cpu_req = 1'b0; host_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output int lat);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        if (we) model[a] = d; else cpu_exp.push_back(model[a]);
        lat = 0;
        do begin @(negedge clock); lat++; end while (cpu_ack !== 1'b1 && lat < 20);
        rd = cpu_rdata;
        cpu_req = 1'b0;
    endtask

    task automatic host_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd, output int lat);
        @(negedge clock);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        if (we) model[a] = d; else host_exp.push_back(model[a]);
        lat = 0;
        do begin @(negedge clock); lat++; end while (host_ack !== 1'b1 && lat < 20);
        rd = host_rdata;
        host_req = 1'b0;
    endtask

    task automatic test_reset;
        logic [2*AW+4*DW+4:0] outs;
        do_reset();
        outs = {cpu_ack, host_ack, busy, ram_en, ram_we, ram_addr, ram_wdata,
                cpu_rdata, host_rdata, ram_addr};
        n_vec++;
        if (outs !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
        model[16'h0010] = 8'hA5;
        @(negedge clock);
        n_vec++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack} !== {1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0}) begin
            n_err++;
            $display("FAIL reset_first_access: en=%b we=%b addr=%h wdata=%h ack=%b want 1 1 0010 a5 0",
                     ram_en, ram_we, ram_addr, ram_wdata, cpu_ack);
        end
        @(negedge clock);
        n_vec++;
        if ({ram_en, cpu_ack} !== 2'b01) begin
            n_err++; $display("FAIL reset_first_ack: en=%b ack=%b want en=0 ack=1", ram_en, cpu_ack);
        end
        cpu_req = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({cpu_ack, busy} !== 2'b00) begin
            n_err++; $display("FAIL reset_ack_pulse: ack=%b busy=%b want 0 0", cpu_ack, busy);
        end
    endtask

    task automatic test_host_read;
        logic [DW-1:0] rd, exp;
        int lat, c0;
        c0 = cpu_ack_cnt;
        host_xfer(1'b0, 16'h0010, 8'h00, rd, lat);
        exp = (host_exp.size() > 0) ? host_exp.pop_front() : 8'hxx;
        n_vec++;
        if (rd !== exp) begin
            n_err++; $display("FAIL host_read_data: got %h want %h", rd, exp);
        end
        n_vec++;
        if (lat != 2) begin
            n_err++; $display("FAIL host_read_latency: got %0d want 2", lat);
        end
        n_vec++;
        if (cpu_ack_cnt != c0) begin
            n_err++; $display("FAIL host_read_cpu_ack: got %0d cpu acks want 0", cpu_ack_cnt - c0);
        end
    endtask

    task automatic test_contention;
        int who[4];
        int when[4];
        int n;
        int t;
        do_reset();
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 16'h0010;  cpu_wdata = 8'h00;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010; host_wdata = 8'h00;
        n = 0; t = 0;
        while (n < 4 && t < 30) begin
            @(negedge clock);
            t++;
            if (cpu_ack === 1'b1 && host_ack === 1'b1) begin
                n_vec++; n_err++; $display("FAIL contention_dual_ack: both acks high at cycle %0d", t);
            end else if (cpu_ack === 1'b1 || host_ack === 1'b1) begin
                who[n] = host_ack ? 1 : 0;
                when[n] = t;
                n_vec++;
                if ((cpu_ack ? cpu_rdata : host_rdata) !== model[16'h0010]) begin
                    n_err++; $display("FAIL contention_rdata: got %h want %h",
                                      cpu_ack ? cpu_rdata : host_rdata, model[16'h0010]);
                end
                n++;
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        n_vec++;
        if (n != 4) begin
            n_err++; $display("FAIL contention_count: got %0d acks want 4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (who[k] != (k % 2)) begin
                    n_err++; $display("FAIL contention_order[%0d]: got owner %0d want %0d", k, who[k], k % 2);
                end
                n_vec++;
                if (when[k] != 2 + 3 * k) begin
                    n_err++; $display("FAIL contention_timing[%0d]: got cycle %0d want %0d", k, when[k], 2 + 3 * k);
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic test_field_stability;
        logic [DW-1:0] rd, exp;
        int lat;
        cpu_xfer(1'b1, 16'h0020, 8'h5A, rd, lat);
        cpu_xfer(1'b1, 16'h0030, 8'h6B, rd, lat);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        exp = model[16'h0020];
        @(negedge clock);
        n_vec++;
        if ({ram_en, ram_addr} !== {1'b1, 16'h0020}) begin
            n_err++; $display("FAIL field_addr: en=%b addr=%h want 1 0020", ram_en, ram_addr);
        end
        cpu_addr = 16'h0030; cpu_we = 1'b1; cpu_wdata = 8'hFF;
        @(negedge clock);
        n_vec++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, exp}) begin
            n_err++; $display("FAIL field_rdata: ack=%b data=%h want 1 %h", cpu_ack, cpu_rdata, exp);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        logic [DW-1:0] rd, exp;
        int lat, c0;
        cpu_xfer(1'b1, 16'h0040, 8'h77, rd, lat);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h3C;
        @(negedge clock);
        c0 = cpu_ack_cnt;
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        n_vec++;
        if ({ram_en, ram_we} !== 2'b00) begin
            n_err++; $display("FAIL midwrite_gate: en=%b we=%b want 0 0", ram_en, ram_we);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if (cpu_ack_cnt != c0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midwrite_noack: acks=%0d busy=%b want 0 0", cpu_ack_cnt - c0, busy);
        end
        cpu_xfer(1'b0, 16'h0040, 8'h00, rd, lat);
        exp = (cpu_exp.size() > 0) ? cpu_exp.pop_front() : 8'hxx;
        n_vec++;
        if (rd !== exp) begin
            n_err++; $display("FAIL midwrite_readback: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_full_run;
        logic [DW-1:0] rd, exp;
        logic [8:0]    sum;
        int lat;
        host_xfer(1'b1, 16'h00F0, 8'hC3, rd, lat);
        for (int i = 0; i < 16; i++) begin
            host_xfer(1'b1, AW'(i), DW'(i * 7 + 3), rd, lat);
            n_vec++;
            if (lat != 2) begin
                n_err++; $display("FAIL load_latency[%0d]: got %0d want 2", i, lat);
            end
        end
        fork
            begin
                logic [DW-1:0] a, b, e;
                int l;
                for (int j = 0; j < 8; j++) begin
                    cpu_xfer(1'b0, AW'(2 * j), 8'h00, a, l);
                    e = (cpu_exp.size() > 0) ? cpu_exp.pop_front() : 8'hxx;
                    n_vec++;
                    if (a !== e || l > 5) begin
                        n_err++; $display("FAIL run_cpu_read[%0d]: data %h lat %0d want %h lat<=5", 2 * j, a, l, e);
                    end
                    cpu_xfer(1'b0, AW'(2 * j + 1), 8'h00, b, l);
                    e = (cpu_exp.size() > 0) ? cpu_exp.pop_front() : 8'hxx;
                    n_vec++;
                    if (b !== e || l > 5) begin
                        n_err++; $display("FAIL run_cpu_read[%0d]: data %h lat %0d want %h lat<=5", 2 * j + 1, b, l, e);
                    end
                    cpu_xfer(1'b1, AW'(16'h0100 + j), DW'(({1'b0, a} + {1'b0, b}) >> 1), e, l);
                    n_vec++;
                    if (l > 5) begin
                        n_err++; $display("FAIL run_cpu_write[%0d]: lat %0d want <=5", j, l);
                    end
                end
            end
            begin
                logic [DW-1:0] p, e;
                int l;
                for (int q = 0; q < 12; q++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    host_xfer(1'b0, 16'h00F0, 8'h00, p, l);
                    e = (host_exp.size() > 0) ? host_exp.pop_front() : 8'hxx;
                    n_vec++;
                    if (p !== e || l > 5) begin
                        n_err++; $display("FAIL run_poll[%0d]: data %h lat %0d want %h lat<=5", q, p, l, e);
                    end
                end
            end
        join
        for (int j = 0; j < 8; j++) begin
            sum = 9'((2 * j) * 7 + 3) + 9'((2 * j + 1) * 7 + 3);
            host_xfer(1'b0, AW'(16'h0100 + j), 8'h00, rd, lat);
            exp = (host_exp.size() > 0) ? host_exp.pop_front() : 8'hxx;
            n_vec++;
            if (rd !== sum[8:1] || rd !== exp) begin
                n_err++; $display("FAIL run_result[%0d]: got %h want %h", j, rd, sum[8:1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        test_reset();
        test_host_read();
        test_contention();
        test_field_stability();
        test_reset_mid_write();
        test_full_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/image_mem_arbiter.md
Name: image_mem_arbiter

Overview:
- Arbitrates the single-port image RAM between two requesters: the down-sample processor core (MAR/MDR path) and the host loader/dumper, which fills source pixels before `start` and reads results after `finished`.
- Sits between the core and the RAM inside the top-level wrapper.
- Each transfer uses a registered request/ack handshake and is one byte wide.
- Round-robin arbitration means a host poll can never starve the core, and the core can never starve the host.

Parameters:
- ADDR_W, 16, address width; matches MAR.
- DATA_W, 8, data width; matches MDR.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  core access request; held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  core address (MAR).
- cpu_wdata  in  DATA_W  core write data (MDR out).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1.
- host_req  in  1  host access request.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  host completion pulse.
- host_rdata  out  DATA_W  host read data, valid while host_ack=1.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM synchronous read output; valid in the cycle after ram_en.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- **States:** IDLE, ACCESS, ACK. State, owner, last_owner and the latched request fields (we, addr, wdata) are all registers.
- **Reset values:**
  - state = IDLE, owner = CPU, last_owner = HOST (so the core wins the first contention).
  - cpu_ack = host_ack = 0, busy = 0.
  - ram_en = ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - cpu_rdata = host_rdata = 0.
- **Synchronous reset in ACCESS:** ram_en and ram_we are combinationally gated by ~reset, so no write commits at the reset edge. No ack is issued. The aborted request is re-arbitrated from IDLE if it is still asserted after reset.
- **IDLE:**
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both high: grant the requester that is not last_owner.
  - On a grant: latch that requester's we/addr/wdata, set owner, go to ACCESS.
- **ACCESS (1 cycle):**
  - ram_en = 1, ram_we = latched we, ram_addr / ram_wdata = latched fields.
  - Next state is ACK; last_owner <= owner.
- **ACK (1 cycle):**
  - The owner's ack = 1; the other requester's ack = 0.
  - Owner rdata = ram_rdata, registered from the read data at entry to ACK and held until the next ack to that owner.
  - For writes, rdata is unchanged.
  - Next state is IDLE.
- **Latency:** a req sampled high at edge E0 in IDLE produces ack high in the cycle after edge E1, i.e. the second cycle after the request is sampled. Minimum period between back-to-back grants is 3 cycles.
- **Handshake rules:**
  - Requesters hold req/we/addr/wdata stable until they see ack.
  - A requester drops req at the edge that ends its ACK cycle.
  - req is ignored in ACCESS and ACK.
  - A req still high in IDLE after an ack is treated as a new request.
- **Field latching:** request fields are captured only at the grant edge. Changes to them during ACCESS or ACK have no effect.
- **Contention fairness:** with both reqs held continuously, grants strictly alternate CPU, HOST, CPU, ...
- **Address range:** address wrap is not applicable. ram_addr passes the full ADDR_W bits unchanged.
- **Outputs:** all outputs are decoded from registered state only; there are no combinational paths from req inputs to outputs, except the ~reset gating on ram_en/ram_we.

Test Plan:
- **Reset:** after reset, all outputs read 0 and busy = 0. Then assert cpu_req with we=1, addr=0x0010, wdata=0xA5 → ram_en=1 with ram_we=1, ram_addr=0x0010, ram_wdata=0xA5 for exactly 1 cycle, and cpu_ack=1 exactly 2 cycles after the request is sampled.
- **Host read after CPU write:** host_req with we=0, addr=0x0010 → host_ack=1 with host_rdata=0xA5; cpu_ack stays 0 throughout.
- **Simultaneous requests from reset:** cpu_req and host_req asserted together and held through 4 grants → grant order CPU, HOST, CPU, HOST. Each ack pulse is 1 cycle, and successive acks are spaced 3 cycles apart.
- **Field stability:** cpu_addr changes from 0x0020 to 0x0030 during ACCESS → ram_addr stays 0x0020 and the read returns the data stored at 0x0020.
- **Reset mid-write:** reset asserted during the ACCESS cycle of a write of 0x3C to 0x0040 → ram_we=0 at that edge, no ack is issued, and a later read of 0x0040 returns its previous value.
- **Full processor run:** host loads 16 bytes, then `start`, with host polling reads interleaved during the run → the processor reaches `finished` with results identical to the no-polling run, and no request waits more than 3 cycles in IDLE before being granted.
